// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: producer handshake, RAM write port,
// outgoing Gray write pointer, incoming synchronized read pointer and status.
interface async_fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wvalid_i;
  logic                  wready_o;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [ADDR_WIDTH:0]   wptr_gray_o;
  logic [ADDR_WIDTH:0]   rptr_gray_sync_i;
  logic                  wfull_o;
  logic                  walmost_full_o;
  logic [ADDR_WIDTH:0]   wlevel_o;

  // Controller side.
  modport slave (
    input  wvalid_i,
    input  rptr_gray_sync_i,
    output wready_o,
    output wen_o,
    output waddr_o,
    output wptr_gray_o,
    output wfull_o,
    output walmost_full_o,
    output wlevel_o
  );

  // Producer / read-domain side.
  modport master (
    output wvalid_i,
    output rptr_gray_sync_i,
    input  wready_o,
    input  wen_o,
    input  waddr_o,
    input  wptr_gray_o,
    input  wfull_o,
    input  walmost_full_o,
    input  wlevel_o
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Dual-clock FIFO write controller: 1-cycle pointer/flag update after a write, 3+ cycles from a read pop to full release.
// Backpressure: wready_o = ~wfull_o; wvalid_i may stay high while full, nothing is written or lost. ADDR_WIDTH must be >= 2.
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  async_fifo_wr_ctrl_if.slave  wif
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;

  logic          wen;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] wlevel_next;

  assign wen        = wif.wvalid_i & ~wfull;
  assign wbin_next  = wbin + {{(PW-1){1'b0}}, wen};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_sync[i] = ^(wif.rptr_gray_sync_i >> i);
    end
  end

  // Full when our pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_gray   = {~wif.rptr_gray_sync_i[PW-1:PW-2], wif.rptr_gray_sync_i[PW-3:0]};
  assign wlevel_next = wbin_next - rbin_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbin         <= '0;
      wgray        <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wgray        <= wgray_next;
      wfull        <= (wgray_next == full_gray);
      walmost_full <= (wlevel_next >= AFULL_LVL);
      wlevel       <= wlevel_next;
    end
  end

  assign wif.wready_o       = ~wfull;
  assign wif.wen_o          = wen;
  assign wif.waddr_o        = wbin[ADDR_WIDTH-1:0];
  assign wif.wptr_gray_o    = wgray;
  assign wif.wfull_o        = wfull;
  assign wif.walmost_full_o = walmost_full;
  assign wif.wlevel_o       = wlevel;

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-domain controller for the dual-clock FIFO. It runs entirely on the write clock and does four jobs:
- Accepts writes with a valid/ready handshake.
- Drives the shared RAM write address and write enable.
- Publishes a registered Gray-coded write pointer. The read domain brings this pointer in through its 2-FF synchronizer.
- Computes full, almost-full and fill level from the read pointer after that pointer has been synchronized into the write domain.

Parameters:
ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2**ADDR_WIDTH (pointers are ADDR_WIDTH+1 bits).
AFULL_THRESH, 12, almost-full asserts when fill level >= this value; legal range 1..2**ADDR_WIDTH.

Ports:
clk_i  in  1  write-domain clock.
rst_i  in  1  reset; asynchronous, active-high.
wvalid_i  in  1  producer has a word to write this cycle.
wready_o  out  1  controller can accept a word; equals ~wfull_o.
wen_o  out  1  RAM write enable; equals wvalid_i & wready_o (combinational).
waddr_o  out  ADDR_WIDTH  RAM write address; the low ADDR_WIDTH bits of the binary write pointer.
wptr_gray_o  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
rptr_gray_sync_i  in  ADDR_WIDTH+1  read Gray pointer, already 2-FF synchronized into clk_i.
wfull_o  out  1  registered full flag.
walmost_full_o  out  1  registered almost-full flag.
wlevel_o  out  ADDR_WIDTH+1  registered, conservative fill level (0..2**ADDR_WIDTH).

Behaviour:
- State registers:
  - wbin: binary write pointer, ADDR_WIDTH+1 bits.
  - wgray: Gray write pointer, drives wptr_gray_o.
  - wfull, walmost_full, wlevel.
- Reset (rst_i=1, asynchronous): all registers clear to 0.
  - Outputs: wready_o=1, wfull_o=0, walmost_full_o=0, wlevel_o=0, wptr_gray_o=0, waddr_o=0.
  - Reset deasserts synchronously to clk_i.
- Write accept: a write is accepted on a rising edge when wen_o=1.
  - The data word is written to RAM at waddr_o in that same cycle.
  - wbin increments by 1 on the following edge.
- Pointer update, every cycle:
  - wbin_next = wbin + wen_o, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both are registered.
  - wptr_gray_o is driven only from a flop, with no combinational logic after it.
  - wptr_gray_o changes at most 1 bit per cycle.
- Full:
  - wfull next = (wgray_next == {~rptr_gray_sync_i[MSB:MSB-1], rptr_gray_sync_i[MSB-2:0]}).
  - The flag is registered, so it asserts on the same edge that stores the last free entry. A write in the full state is therefore impossible.
- Level and almost-full:
  - rbin_sync = Gray-to-binary of rptr_gray_sync_i (combinational XOR prefix).
  - wlevel next = (wbin_next - rbin_sync) modulo 2**(ADDR_WIDTH+1).
  - walmost_full next = (wlevel next >= AFULL_THRESH).
- Latency:
  - Write to full/level/pointer update: 1 cycle.
  - Read-side pop to wfull_o deassert: at least 3 clk_i cycles (2-FF synchronizer plus the flag register). Level and full are pessimistic, never optimistic.
- Boundary conditions:
  - Wrap-around: wbin rolls from 2**(ADDR_WIDTH+1)-1 to 0 with no special case. waddr_o wraps every 2**ADDR_WIDTH writes. The pointer MSB distinguishes full from empty.
  - Simultaneous write on the last free slot while rptr_gray_sync_i advances in the same cycle: wfull next is evaluated with the new synced pointer, so the flag does not falsely assert.
  - wvalid_i while wfull_o=1: no write; wbin and wgray hold; wready_o=0. wvalid_i may stay asserted; there is no loss and no error.
  - rptr_gray_sync_i multi-bit jumps never occur by construction. The block does not need to tolerate them.
  - Reset mid-operation: pointers return to 0 immediately. The system must reset the read domain in the same window; the block performs no recovery.

Test Plan:
(ADDR_WIDTH=4, AFULL_THRESH=12)
1. Reset with wvalid_i=1 held:
   - During reset: wready_o=1, wen_o=1 combinational, but wbin stays 0.
   - After rst_i falls: first edge stores at waddr_o=0, then wptr_gray_o=0b00001.
2. 16 back-to-back writes with rptr_gray_sync_i=0:
   - waddr_o steps 0..15.
   - walmost_full_o rises after the 12th accepted write (wlevel_o=12).
   - wfull_o rises after the 16th (wlevel_o=16, wptr_gray_o=0b11000).
   - 17th request is held: wready_o=0, wen_o=0, pointer unchanged.
3. From full, step rptr_gray_sync_i to 0b00001:
   - Next edge: wfull_o=0, wlevel_o=15, wready_o=1.
   - One more write: wfull_o=1 again, wptr_gray_o=0b11001.
4. Continuous write/read streaming for 40 words, with the read pointer lagging 3 cycles:
   - wbin wraps through 31 to 0.
   - Every wptr_gray_o change is exactly 1 bit.
   - wlevel_o never exceeds 16; no full glitch.
5. Level = 15 with write and read-pointer advance in the same cycle:
   - wfull_o stays 0; wlevel_o stays 15.
6. Assert rst_i asynchronously mid-burst at level 9:
   - All outputs go to their reset values before the next clk_i edge.
   - Writes resume from waddr_o=0.
